// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for the up/down counter: stimulus side drives the
// controls, the counter drives the count, flags and cascade look-ahead.
interface counter_updown_mod_if #(
  parameter int DW = 8
) ();
  logic          ena;
  logic          up;
  logic          wrap;
  logic          load;
  logic [DW-1:0] load_val;
  logic [DW-1:0] limit;
  logic [DW-1:0] result;
  logic          tc;
  logic          done;
  logic          tc_next;

  modport master (
    output ena, up, wrap, load, load_val, limit,
    input  result, tc, done, tc_next
  );

  modport slave (
    input  ena, up, wrap, load, load_val, limit,
    output result, tc, done, tc_next
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter over the range 0..limit with wrap or one-shot mode,
// synchronous load, terminal-count pulse, sticky done flag and cascade output.
module counter_updown_mod #(
  parameter int          DW   = 8,
  parameter int unsigned INIT = 7
) (
  input  logic               clk,
  input  logic               reset,
  counter_updown_mod_if.slave bus
);
  localparam logic [DW-1:0] INIT_V = DW'(INIT);

  logic [DW-1:0] result_q, result_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;
  logic          atTerminal;
  logic          tcNext;

  // Counting up, anything at or above limit is terminal so an out-of-range
  // value (after limit is lowered) reloads instead of running past it.
  always_comb begin
    atTerminal = bus.up ? (result_q >= bus.limit) : (result_q == '0);
    tcNext     = bus.ena & ~bus.load & ~reset & atTerminal & (bus.wrap | ~done_q);
  end

  always_comb begin
    result_d = result_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      result_d = (bus.load_val < bus.limit) ? bus.load_val : bus.limit;
      done_d   = 1'b0;
    end else if (bus.ena) begin
      if (atTerminal) begin
        tc_d = bus.wrap | ~done_q;
        if (bus.wrap) begin
          result_d = bus.up ? '0 : bus.limit;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        result_d = bus.up ? result_q + DW'(1) : result_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= INIT_V;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.tc      = tc_q;
  assign bus.done    = done_q;
  assign bus.tc_next = tcNext;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed plus short random sequence against a behavioural reference model;
// expected register values travel through a scoreboard queue.
module tb_counter_updown_mod;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          tc;
    logic          done;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sbq[$];

  logic [DW-1:0] mRes;
  logic          mTc;
  logic          mDone;

  counter_updown_mod_if #(.DW(DW)) bus ();

  counter_updown_mod #(.DW(DW), .INIT(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbq.pop_front();
      compare("result", bus.result, e.res);
      compare("tc", DW'(bus.tc), DW'(e.tc));
      compare("done", DW'(bus.done), DW'(e.done));
    end
  endtask

  // Drives one cycle of controls, checks the look-ahead, advances the model,
  // then compares registered outputs after the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic u,
                               input logic w, input logic ld,
                               input logic [DW-1:0] lv, input logic [DW-1:0] lim);
    logic term;
    logic tcn;
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.ena      = en;
    bus.up       = u;
    bus.wrap     = w;
    bus.load     = ld;
    bus.load_val = lv;
    bus.limit    = lim;
    #1;
    if (u) term = (mRes >= lim);
    else   term = (mRes == 0);
    tcn = en && !ld && !rst && term && (w || !mDone);
    if (!rst) compare("tc_next", DW'(bus.tc_next), DW'(tcn));

    if (rst) begin
      mRes = 8'd7; mTc = 1'b0; mDone = 1'b0;
    end else if (ld) begin
      mRes = (lv > lim) ? lim : lv; mTc = 1'b0; mDone = 1'b0;
    end else if (en && term) begin
      if (w) begin
        mTc  = 1'b1;
        mRes = u ? 8'd0 : lim;
      end else begin
        mTc   = !mDone;
        mDone = 1'b1;
      end
    end else if (en) begin
      mTc  = 1'b0;
      mRes = u ? mRes + 8'd1 : mRes - 8'd1;
    end else begin
      mTc = 1'b0;
    end
    e.res = mRes; e.tc = mTc; e.done = mDone;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mRes = '0; mTc = 1'b0; mDone = 1'b0;
    reset = 1'b1;
    bus.ena = 1'b0; bus.up = 1'b0; bus.wrap = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.limit = 8'd7;

    // reset, including with load and ena high
    applyStimulus(1, 0, 0, 0, 0, 8'd0, 8'd7);
    applyStimulus(1, 1, 1, 1, 1, 8'd99, 8'd7);
    compare("reset_init", bus.result, 8'd7);

    // one-shot down count from INIT to 0, then hold at terminal
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, 8'd0, 8'd7);
    compare("down_reached_0", bus.result, 8'd0);
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 8'd7);
    compare("oneshot_tc", DW'(bus.tc), 8'd1);
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 8'd7);
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 8'd7);

    // switching to wrap does not clear done; wrap down reload to limit
    applyStimulus(0, 0, 0, 1, 0, 8'd0, 8'd7);
    applyStimulus(0, 1, 0, 1, 0, 8'd0, 8'd7);

    // wrap up with limit 3 from 0
    applyStimulus(0, 0, 1, 1, 1, 8'd0, 8'd3);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 1, 0, 8'd0, 8'd3);

    // load clamps to limit and overrides ena
    applyStimulus(0, 1, 1, 0, 1, 8'd200, 8'd50);
    compare("load_clamp", bus.result, 8'd50);

    // limit lowered below result: up reloads, down decrements
    applyStimulus(0, 0, 1, 1, 1, 8'd40, 8'd50);
    applyStimulus(0, 1, 1, 1, 0, 8'd0, 8'd10);
    applyStimulus(0, 0, 1, 1, 1, 8'd40, 8'd50);
    applyStimulus(0, 1, 0, 1, 0, 8'd0, 8'd10);
    compare("oor_down", bus.result, 8'd39);

    // reset while counting
    applyStimulus(0, 0, 1, 1, 1, 8'd4, 8'd50);
    applyStimulus(0, 1, 1, 1, 0, 8'd0, 8'd50);
    applyStimulus(1, 1, 1, 1, 0, 8'd0, 8'd50);
    applyStimulus(0, 1, 1, 1, 0, 8'd0, 8'd50);

    // limit 0: every step terminal in both directions
    applyStimulus(0, 0, 1, 1, 1, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, 0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 8'd0, 8'd0);

    // idle hold, then one-shot up to limit
    applyStimulus(0, 0, 1, 1, 0, 8'd0, 8'd0);
    applyStimulus(0, 0, 1, 0, 1, 8'd3, 8'd5);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0, 8'd0, 8'd5);

    // short random sequence with small limits
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 12)),
                    8'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
